// File: rtl/serial_subtractor_n_if.sv
// Handshake and operand bus for serial_subtractor_n.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_n_if #(
    parameter int BITS = 8
);
    logic            start;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            bin;
    logic            busy;
    logic            done;
    logic [BITS-1:0] diff;
    logic            bout;
`ifdef SERIAL_SUB_OVF_EN
    logic            ovf;
`endif

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_n.sv
// Bit-serial subtractor: diff = a - b - bin over BITS cycles, LSB first, start/done handshake.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_n #(
    parameter int BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_n_if.slave  sub
);
    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q;
    logic [BITS-1:0] ra_q, rb_q, res_q, diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic            brw_q, bout_q, busy_q, done_q;
`ifdef SERIAL_SUB_OVF_EN
    logic            a_msb_q, b_msb_q, ovf_q;
`endif

    logic            x, y, dbit, brw_d;
    logic [BITS-1:0] res_d;

    always_comb begin
        x     = ra_q[0];
        y     = rb_q[0];
        dbit  = x ^ y ^ brw_q;
        brw_d = (~x & y) | (~(x ^ y) & brw_q);
        // Result fills from the MSB so it is aligned after the last bit.
        res_d           = res_q >> 1;
        res_d[BITS-1]   = dbit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (sub.start) begin
                        ra_q    <= sub.a;
                        rb_q    <= sub.b;
                        brw_q   <= sub.bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= sub.a[BITS-1];
                        b_msb_q <= sub.b[BITS-1];
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    brw_q <= brw_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Final bit: publish the outputs so they are valid with done.
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= brw_d;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (dbit != a_msb_q);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sub.busy = busy_q;
    assign sub.done = done_q;
    assign sub.diff = diff_q;
    assign sub.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign sub.ovf  = ovf_q;
`endif
endmodule
